// File: rtl/snake_body_queue.sv
// Snake body occupancy queue: circular buffer of head positions with
// self-collision scan and serialised erase-tail / draw-head pixel commands.
module snake_body_queue #(
    parameter int MAX_LEN = 64,
    parameter int PTR_W   = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic [7:0]       head_x,
    input  logic [6:0]       head_y,
    input  logic             grow,
    input  logic [2:0]       head_colour,
    output logic [7:0]       x_out,
    output logic [6:0]       y_out,
    output logic [2:0]       colour_out,
    output logic             plot,
    output logic             busy,
    output logic             done,
    output logic [PTR_W:0]   length,
    output logic             self_hit
);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        ERASE,
        DRAW,
        DONE,
        HALT
    } state_t;

    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(MAX_LEN);

    state_t             state, state_nx;
    logic [14:0]        mem [MAX_LEN];
    logic [PTR_W-1:0]   head_ptr, tail_ptr, scan_idx;
    logic [PTR_W:0]     scan_cnt, scan_cnt_ld;
    logic [7:0]         hx;
    logic [6:0]         hy;
    logic [2:0]         hc;
    logic               grow_eff, grow_eff_in, scan_hit;
    logic [14:0]        tail_entry;

    // A full buffer never grows; an empty one always does.
    assign grow_eff_in = (grow || (length == '0)) && (length != FULL);
    assign scan_cnt_ld = grow_eff_in ? length : length - (PTR_W+1)'(1);
    assign scan_hit    = (mem[scan_idx] == {hx, hy});
    assign tail_entry  = mem[tail_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        plot       = 1'b0;
        x_out      = '0;
        y_out      = '0;
        colour_out = '0;
        done       = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE:  if (tick) state_nx = (scan_cnt_ld != '0) ? SCAN : ERASE;
            SCAN: begin
                if (scan_hit)                           state_nx = DONE;
                else if (scan_cnt == (PTR_W+1)'(1))     state_nx = ERASE;
            end
            ERASE: begin
                if (!grow_eff) begin
                    plot  = 1'b1;
                    x_out = tail_entry[14:7];
                    y_out = tail_entry[6:0];
                end
                state_nx = DRAW;
            end
            DRAW: begin
                plot       = 1'b1;
                x_out      = hx;
                y_out      = hy;
                colour_out = hc;
                state_nx   = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = self_hit ? HALT : IDLE;
            end
            HALT:    state_nx = HALT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            length   <= '0;
            self_hit <= 1'b0;
            scan_idx <= '0;
            scan_cnt <= '0;
            hx       <= '0;
            hy       <= '0;
            hc       <= '0;
            grow_eff <= 1'b0;
        end else begin
            case (state)
                IDLE: if (tick) begin
                    hx       <= head_x;
                    hy       <= head_y;
                    hc       <= head_colour;
                    grow_eff <= grow_eff_in;
                    scan_cnt <= scan_cnt_ld;
                    // The departing tail is skipped when the move does not grow.
                    scan_idx <= grow_eff_in ? tail_ptr : tail_ptr + PTR_W'(1);
                end
                SCAN: begin
                    if (scan_hit) self_hit <= 1'b1;
                    scan_idx <= scan_idx + PTR_W'(1);
                    scan_cnt <= scan_cnt - (PTR_W+1)'(1);
                end
                ERASE: if (!grow_eff) begin
                    tail_ptr <= tail_ptr + PTR_W'(1);
                    length   <= length - (PTR_W+1)'(1);
                end
                DRAW: begin
                    head_ptr <= head_ptr + PTR_W'(1);
                    length   <= length + (PTR_W+1)'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == DRAW) mem[head_ptr] <= {hx, hy};
    end

endmodule

// File: tb/tb_snake_body_queue.sv
// Randomised self-checking bench: a queue-based body model predicts every
// cycle's outputs, and one compare process checks the DUT against it.
module tb_snake_body_queue;

    logic       clk = 1'b0;
    logic       reset_n, tick, grow;
    logic [7:0] head_x;
    logic [6:0] head_y;
    logic [2:0] head_colour;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       plot, busy, done, self_hit;
    logic [6:0] length;

    snake_body_queue #(.MAX_LEN(64), .PTR_W(6)) dut (
        .clk(clk), .reset_n(reset_n), .tick(tick), .head_x(head_x),
        .head_y(head_y), .grow(grow), .head_colour(head_colour),
        .x_out(x_out), .y_out(y_out), .colour_out(colour_out), .plot(plot),
        .busy(busy), .done(done), .length(length), .self_hit(self_hit)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       plot;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       busy;
        logic       done;
        logic       sh;
        logic [6:0] len;
    } exp_t;

    int   checks = 0;
    int   fails  = 0;
    logic [14:0] body[$];
    exp_t seq[$];
    exp_t last_seq[$];
    exp_t exp_q[$];
    exp_t last_e = '0;
    bit   halted = 0;
    bit   m_sh   = 0;

    function automatic exp_t mk(bit p, logic [7:0] x, logic [6:0] y, logic [2:0] c,
                                bit b, bit d, bit sh, int len);
        exp_t e;
        e.plot = p; e.x = x; e.y = y; e.c = c;
        e.busy = b; e.done = d; e.sh = sh; e.len = 7'(len);
        return e;
    endfunction

    // Expand one accepted move into its per-cycle output sequence.
    task automatic build(logic [7:0] x, logic [6:0] y, bit g, logic [2:0] c);
        int L = body.size();
        bit ge = (g || L == 0) && L != 64;
        int first = ge ? 0 : 1;
        int hit = -1;
        logic [14:0] hv = {x, y};
        logic [14:0] tl;
        for (int i = first; i < L; i++)
            if (hit < 0 && body[i] == hv) hit = i - first;
        if (hit >= 0) begin
            for (int k = 0; k <= hit; k++) seq.push_back(mk(0, 0, 0, 0, 1, 0, 0, L));
            seq.push_back(mk(0, 0, 0, 0, 1, 1, 1, L));
            m_sh = 1;
            halted = 1;
        end else begin
            for (int k = 0; k < L - first; k++) seq.push_back(mk(0, 0, 0, 0, 1, 0, 0, L));
            tl = ge ? 15'd0 : body[0];
            seq.push_back(mk(!ge, tl[14:7], tl[6:0], 0, 1, 0, 0, L));
            if (!ge) void'(body.pop_front());
            seq.push_back(mk(1, x, y, c, 1, 0, 0, body.size()));
            body.push_back(hv);
            seq.push_back(mk(0, 0, 0, 0, 1, 1, 0, body.size()));
        end
        last_seq = seq;
    endtask

    task automatic advance(bit t, logic [7:0] x, logic [6:0] y, bit g, logic [2:0] c, bit rn);
        exp_t e;
        if (!rn) begin
            body.delete(); seq.delete(); halted = 0; m_sh = 0;
            e = '0;
        end else if (seq.size() > 0) e = seq.pop_front();
        else if (halted) e = mk(0, 0, 0, 0, 1, 0, 1, body.size());
        else if (t && !last_e.busy) begin
            build(x, y, g, c);
            e = seq.pop_front();
        end else e = mk(0, 0, 0, 0, 0, 0, m_sh, body.size());
        last_e = e;
        exp_q.push_back(e);
    endtask

    task automatic step(bit t, logic [7:0] x, logic [6:0] y, bit g, logic [2:0] c, bit rn);
        @(negedge clk);
        reset_n = rn; tick = t; head_x = x; head_y = y; grow = g; head_colour = c;
        advance(t, x, y, g, c, rn);
    endtask

    // Run the current move to completion, throwing stray ticks that must be dropped.
    task automatic finish_move(bit stray);
        while (seq.size() > 0)
            step(stray && ($urandom % 4 == 0), 8'($urandom), 7'($urandom), 1'($urandom), 3'($urandom), 1);
        step(0, 0, 0, 0, 0, 1);
    endtask

    task automatic move(logic [7:0] x, logic [6:0] y, bit g, logic [2:0] c);
        step(1, x, y, g, c, 1);
        finish_move(1);
    endtask

    task automatic do_reset();
        repeat (2) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
    endtask

    task automatic check_lit(string name, bit ok);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: model got 0, required 1", name);
        end
    endtask

    always @(posedge clk) begin
        exp_t e, a;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = mk(plot, x_out, y_out, colour_out, busy, done, self_hit, int'(length));
            checks++;
            if (a !== e) begin
                fails++;
                $display("FAIL cycle_out @%0t: got plot=%b x=%0d y=%0d c=%b busy=%b done=%b sh=%b len=%0d, required plot=%b x=%0d y=%0d c=%b busy=%b done=%b sh=%b len=%0d",
                         $time, a.plot, a.x, a.y, a.c, a.busy, a.done, a.sh, a.len,
                         e.plot, e.x, e.y, e.c, e.busy, e.done, e.sh, e.len);
            end
        end
    end

    initial begin
        reset_n = 0; tick = 0; grow = 0; head_x = 0; head_y = 0; head_colour = 0;
        do_reset();

        move(10, 20, 0, 3'b100);
        check_lit("t1_seq", last_seq.size() == 3 && !last_seq[0].plot &&
                  last_seq[1] == mk(1, 10, 20, 3'b100, 1, 0, 0, 0) && last_seq[2].done);
        check_lit("t1_len", body.size() == 1);

        move(11, 20, 0, 3'b100);
        check_lit("t2_erase", last_seq[0] == mk(1, 10, 20, 0, 1, 0, 0, 1) &&
                  last_seq[1] == mk(1, 11, 20, 3'b100, 1, 0, 0, 0));
        check_lit("t2_body", body.size() == 1 && body[0] == {8'd11, 7'd20});

        do_reset();
        for (int i = 11; i <= 14; i++) move(8'(i), 20, 1, 3'b010);
        move(13, 20, 0, 3'b010);
        check_lit("hit_seq", m_sh && last_seq.size() == 3 && last_seq[2].done && last_seq[2].sh);
        for (int i = 0; i < 6; i++) begin
            step(1, 8'(30 + i), 5, 0, 3'b001, 1);
            repeat (3) step(0, 0, 0, 0, 0, 1);
        end

        do_reset();
        move(5, 5, 1, 3'b110);
        move(6, 5, 1, 3'b110);
        move(5, 5, 0, 3'b110);
        check_lit("vacate", !m_sh && last_seq.size() == 4 &&
                  last_seq[1] == mk(1, 5, 5, 0, 1, 0, 0, 2) &&
                  last_seq[2] == mk(1, 5, 5, 3'b110, 1, 0, 0, 1));

        do_reset();
        for (int i = 0; i < 136; i++) move(8'(i), 30, 1, 3'b011);
        check_lit("wrap_body", body.size() == 64 && body[0] == {8'd72, 7'd30});

        do_reset();
        for (int i = 0; i < 10; i++) move(8'(20 + i), 40, 1, 3'b101);
        step(1, 100, 100, 0, 3'b101, 1);
        repeat (3) step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0, 0, 1);

        for (int n = 0; n < 400; n++) begin
            if (halted || $urandom % 40 == 0) do_reset();
            step(1, 8'($urandom_range(0, 5)), 7'($urandom_range(0, 5)),
                 ($urandom % 3) == 0, 3'($urandom), 1);
            if ($urandom % 25 == 0) begin
                step(0, 0, 0, 0, 0, 1);
                step(0, 0, 0, 0, 0, 0);
                step(0, 0, 0, 0, 0, 1);
            end else finish_move(1);
        end

        repeat (3) @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
